// File: rtl/div_sequencer_pkg.sv
// Shared definitions for the DIV/DIVU sequencer: FSM state encodings and
// default sizes.
package div_sequencer_pkg;

  localparam int DIV_WIDTH = 32;
  localparam int DIV_ITERS = DIV_WIDTH;

  typedef enum logic [1:0] {
    DIV_IDLE = 2'd0,
    DIV_BUSY = 2'd1,
    DIV_DONE = 2'd2
  } div_state_e;

endpackage

// File: rtl/div_sequencer_if.sv
// EX-side handshake between the pipeline (master) and the divide
// sequencer (slave).
interface div_sequencer_if #(
  parameter int WIDTH = div_sequencer_pkg::DIV_WIDTH
);
  logic             start;
  logic             signed_op;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             cancel;
  logic             stall;
  logic             busy;
  logic             result_valid;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, signed_op, dividend, divisor, cancel,
    input  stall, busy, result_valid, hi, lo
  );

  modport slave (
    input  start, signed_op, dividend, divisor, cancel,
    output stall, busy, result_valid, hi, lo
  );
endinterface

// File: rtl/div_sequencer_radix2_step.sv
// One restoring-division step: shift {rem, quo} left and trial-subtract the
// divisor magnitude, producing one quotient bit.
module div_radix2_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem_in,
  input  logic [WIDTH-1:0] quo_in,
  input  logic [WIDTH-1:0] dvs,
  output logic [WIDTH-1:0] rem_out,
  output logic [WIDTH-1:0] quo_out
);
  logic [WIDTH:0] shifted;
  logic           fits;

  // The shifted remainder needs WIDTH+1 bits; the difference always fits
  // back into WIDTH bits because it is smaller than the divisor.
  always_comb begin
    shifted = {rem_in, quo_in[WIDTH-1]};
    fits    = shifted >= {1'b0, dvs};
    rem_out = fits ? (shifted[WIDTH-1:0] - dvs) : shifted[WIDTH-1:0];
    quo_out = {quo_in[WIDTH-2:0], fits};
  end
endmodule

// File: rtl/div_sequencer.sv
// Multi-cycle DIV/DIVU sequencer: stalls EX while iterating, returns the
// quotient on lo and the remainder on hi with a one-cycle valid pulse.
module div_sequencer
  import div_sequencer_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH,
  parameter int ITERS = WIDTH
) (
  input  logic           clk,
  input  logic           resetn,
  div_sequencer_if.slave bus
);
  localparam int CNT_W = $clog2(ITERS + 1);

  div_state_e       state, state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] rem, quo, dvs;
  logic [WIDTH-1:0] rem_nxt, quo_nxt;
  logic [WIDTH-1:0] hi, lo, hi_prev, lo_prev;
  logic             sign_q, sign_r;
  logic             accept, div_zero, last_step, load_res;

  function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] x,
                                                 input logic is_signed);
    logic signed [WIDTH-1:0] sx;
    sx = x;
    return (is_signed && (sx < 0)) ? -x : x;
  endfunction

  function automatic logic [WIDTH-1:0] apply_sign(input logic [WIDTH-1:0] x,
                                                  input logic neg);
    return neg ? -x : x;
  endfunction

  div_radix2_step #(.WIDTH(WIDTH)) u_step (
    .rem_in  (rem),
    .quo_in  (quo),
    .dvs     (dvs),
    .rem_out (rem_nxt),
    .quo_out (quo_nxt)
  );

  assign accept    = (state == DIV_IDLE) && bus.start && !bus.cancel;
  assign div_zero  = (bus.divisor == '0);
  assign last_step = (cnt == CNT_W'(ITERS - 1));
  assign load_res  = (accept && div_zero) ||
                     ((state == DIV_BUSY) && !bus.cancel && last_step);

  always_ff @(posedge clk) begin
    if (!resetn) state <= DIV_IDLE;
    else         state <= state_nxt;
  end

  // start is deliberately ignored in DONE: it still belongs to the
  // instruction that is completing.
  always_comb begin
    state_nxt = state;
    if (bus.cancel) begin
      state_nxt = DIV_IDLE;
    end else begin
      case (state)
        DIV_IDLE: if (bus.start) state_nxt = div_zero ? DIV_DONE : DIV_BUSY;
        DIV_BUSY: if (last_step) state_nxt = DIV_DONE;
        DIV_DONE: state_nxt = DIV_IDLE;
        default:  state_nxt = DIV_IDLE;
      endcase
    end
  end

  always_comb begin
    bus.busy         = (state != DIV_IDLE);
    bus.result_valid = (state == DIV_DONE) && !bus.cancel;
    bus.stall        = !bus.cancel &&
                       (((state == DIV_IDLE) && bus.start) || (state == DIV_BUSY));
    bus.hi           = hi;
    bus.lo           = lo;
  end

  // Results are published on entry to DONE; a flush landing on DONE rolls
  // hi/lo back to the values held before this operation.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      cnt <= '0;
      hi  <= '0;
      lo  <= '0;
    end else begin
      if (accept)
        cnt <= '0;
      else if ((state == DIV_BUSY) && !bus.cancel)
        cnt <= cnt + CNT_W'(1);

      if (accept && div_zero) begin
        hi <= bus.dividend;
        lo <= '1;
      end else if (load_res) begin
        hi <= apply_sign(rem_nxt, sign_r);
        lo <= apply_sign(quo_nxt, sign_q);
      end else if ((state == DIV_DONE) && bus.cancel) begin
        hi <= hi_prev;
        lo <= lo_prev;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (load_res) begin
      hi_prev <= hi;
      lo_prev <= lo;
    end
    if (accept) begin
      rem    <= '0;
      quo    <= magnitude(bus.dividend, bus.signed_op);
      dvs    <= magnitude(bus.divisor, bus.signed_op);
      sign_q <= bus.signed_op & (bus.dividend[WIDTH-1] ^ bus.divisor[WIDTH-1]);
      sign_r <= bus.signed_op & bus.dividend[WIDTH-1];
    end else if (state == DIV_BUSY) begin
      rem <= rem_nxt;
      quo <= quo_nxt;
    end
  end
endmodule

// File: tb/tb_div_sequencer.sv
// Directed bench for div_sequencer: an arithmetic reference model checked
// every cycle, plus literal expectations for each scenario.
`timescale 1ns/1ps
module tb_div_sequencer;
  localparam int W = 32;
  localparam int N = 32;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  div_sequencer_if #(.WIDTH(W)) bus();

  div_sequencer #(.WIDTH(W), .ITERS(N)) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  int errors = 0;
  int checks = 0;
  bit mon_on = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void model_div(input bit sgn, input logic [31:0] a, input logic [31:0] b,
                                    output logic [31:0] q, output logic [31:0] r);
    logic signed [31:0] sa, sb;
    sa = a;
    sb = b;
    if (b == 0) begin
      q = 32'hFFFF_FFFF;
      r = a;
    end else if (!sgn) begin
      q = a / b;
      r = a % b;
    end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      q = 32'h8000_0000;
      r = 32'h0;
    end else begin
      q = sa / sb;
      r = sa % sb;
    end
  endfunction

  // Reference model: timing from the latency rules, values from arithmetic.
  int          m_left = 0;
  bit          m_done = 1'b0;
  logic [31:0] m_hi = 0, m_lo = 0, m_phi = 0, m_plo = 0, pq = 0, pr = 0;

  always @(negedge clk) begin
    bit idle;
    if (mon_on) begin
      idle = !m_done && (m_left == 0);
      chk("mon_stall", bus.stall, !bus.cancel && ((idle && bus.start) || (m_left > 0)));
      chk("mon_busy", bus.busy, !idle);
      chk("mon_valid", bus.result_valid, m_done && !bus.cancel);
      chk("mon_hi", bus.hi, m_hi);
      chk("mon_lo", bus.lo, m_lo);

      if (!resetn) begin
        m_left = 0; m_done = 0; m_hi = 0; m_lo = 0;
      end else if (bus.cancel) begin
        if (m_done) begin m_hi = m_phi; m_lo = m_plo; end
        m_left = 0; m_done = 0;
      end else if (m_done) begin
        m_done = 0;
      end else if (m_left > 0) begin
        m_left--;
        if (m_left == 0) begin
          m_phi = m_hi; m_plo = m_lo; m_hi = pr; m_lo = pq; m_done = 1;
        end
      end else if (bus.start) begin
        model_div(bus.signed_op, bus.dividend, bus.divisor, pq, pr);
        if (bus.divisor == 0) begin
          m_phi = m_hi; m_plo = m_lo; m_hi = pr; m_lo = pq; m_done = 1;
        end else begin
          m_left = N;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Presents an operation at the current cycle (cycle 0) and keeps start high
  // until the result arrives; returns one cycle after result_valid.
  task automatic run_op(input string name, input bit sgn, input logic [31:0] a,
                        input logic [31:0] b, input int exp_n,
                        input logic [31:0] exp_lo, input logic [31:0] exp_hi);
    int n = 0;
    bit got = 0;
    bus.start = 1; bus.signed_op = sgn; bus.dividend = a; bus.divisor = b;
    while (!got && n <= exp_n + 5) begin
      @(negedge clk);
      if (bus.result_valid) got = 1;
      else n++;
    end
    if (!got) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout: no result_valid within %0d cycles", name, exp_n + 5);
    end else begin
      chk({name, "_lat"}, 32'(n), 32'(exp_n));
      chk({name, "_lo"}, bus.lo, exp_lo);
      chk({name, "_hi"}, bus.hi, exp_hi);
    end
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] q, r;
    int vcount;
    bus.start = 0; bus.signed_op = 0; bus.dividend = 0; bus.divisor = 0; bus.cancel = 0;

    model_div(0, 100, 7, q, r);
    chk("model_divu_q", q, 14);
    chk("model_divu_r", r, 2);
    model_div(1, 32'hFFFF_FFF9, 2, q, r);
    chk("model_div_q", q, 32'hFFFF_FFFD);
    chk("model_div_r", r, 32'hFFFF_FFFF);
    model_div(1, 32'h8000_0000, 32'hFFFF_FFFF, q, r);
    chk("model_ovf_q", q, 32'h8000_0000);

    tick(); tick();
    resetn = 1; mon_on = 1;
    @(negedge clk);
    chk("rst_hi", bus.hi, 0);
    chk("rst_lo", bus.lo, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_valid", bus.result_valid, 0);
    tick();

    run_op("divu_100_7", 0, 100, 7, 33, 14, 2);
    bus.start = 0;
    @(negedge clk);
    chk("divu_100_7_busy_after", bus.busy, 0);
    tick();

    run_op("div_m7_2", 1, 32'hFFFF_FFF9, 2, 33, 32'hFFFF_FFFD, 32'hFFFF_FFFF);
    bus.start = 0; tick();
    run_op("div_ovf", 1, 32'h8000_0000, 32'hFFFF_FFFF, 33, 32'h8000_0000, 0);
    bus.start = 0; tick();
    run_op("divu_5_0", 0, 5, 0, 1, 32'hFFFF_FFFF, 5);
    bus.start = 0; tick();

    // Cancel during BUSY, then a fresh operation in the following cycle.
    bus.start = 1; bus.signed_op = 0; bus.dividend = 100; bus.divisor = 7;
    repeat (10) tick();
    bus.cancel = 1;
    @(negedge clk);
    chk("cancel_stall", bus.stall, 0);
    chk("cancel_valid", bus.result_valid, 0);
    tick();
    bus.cancel = 0;
    chk("cancel_hi_kept", bus.hi, 5);
    chk("cancel_lo_kept", bus.lo, 32'hFFFF_FFFF);
    chk("cancel_idle", bus.busy, 0);
    run_op("divu_9_4", 0, 9, 4, 33, 2, 1);
    bus.start = 0; tick();

    // Cancel landing on the DONE cycle suppresses the result.
    bus.start = 1; bus.signed_op = 0; bus.dividend = 20; bus.divisor = 3;
    repeat (33) tick();
    bus.cancel = 1;
    @(negedge clk);
    chk("cdone_valid", bus.result_valid, 0);
    tick();
    bus.cancel = 0; bus.start = 0;
    chk("cdone_hi_kept", bus.hi, 1);
    chk("cdone_lo_kept", bus.lo, 2);
    chk("cdone_idle", bus.busy, 0);
    tick();

    // Reset in the middle of an operation.
    bus.start = 1; bus.signed_op = 0; bus.dividend = 100; bus.divisor = 7;
    repeat (15) tick();
    resetn = 0;
    tick();
    resetn = 1; bus.start = 0;
    chk("midrst_hi", bus.hi, 0);
    chk("midrst_lo", bus.lo, 0);
    chk("midrst_busy", bus.busy, 0);
    vcount = 0;
    repeat (40) begin
      @(negedge clk);
      if (bus.result_valid) vcount++;
    end
    chk("midrst_no_valid", 32'(vcount), 0);
    tick();

    // Back-to-back with start held high through DONE.
    run_op("b2b_first", 0, 100, 7, 33, 14, 2);
    run_op("b2b_second", 0, 32'hFFFF_FFFF, 32'h10, 33, 32'h0FFF_FFFF, 32'hF);
    bus.start = 0;
    tick(); tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/div_sequencer.md
# div_sequencer

Multi-cycle controller and datapath for the DIV/DIVU instructions that write HI/LO. It sits beside the EX stage: it accepts operands from EX, holds the pipeline with a stall while it iterates, and returns quotient (LO) and remainder (HI) with a one-cycle valid pulse. It also aborts cleanly on pipeline flush.

## Interface
Parameters:
- WIDTH, 32, operand/result width
- ITERS, WIDTH, number of restoring-division iterations (one quotient bit per cycle)

Ports:
- clk  in  1  system clock; all state updates on rising edge
- resetn  in  1  synchronous, active-low reset
- start  in  1  EX holds a DIV/DIVU instruction; level signal, stays high while EX is stalled
- signed_op  in  1  1 = DIV, 0 = DIVU; sampled with start
- dividend  in  WIDTH  rs value; sampled at acceptance
- divisor  in  WIDTH  rt value; sampled at acceptance
- cancel  in  1  flush of EX (exception/eret); aborts any operation
- stall  out  1  hold IF..EX this cycle (combinational)
- busy  out  1  state is not IDLE (registered)
- result_valid  out  1  one-cycle pulse; hi/lo are final
- hi  out  WIDTH  remainder, registered, holds until next completion
- lo  out  WIDTH  quotient, registered, holds until next completion

## Operation
- States: IDLE, BUSY, DONE. Encoding constants live in the shared header.
- IDLE:
  - start & !cancel & divisor != 0: latch the operand magnitudes, sign_q = signed_op & (a[31] ^ b[31]), sign_r = signed_op & a[31]. Clear the iteration counter and go to BUSY.
  - start & !cancel & divisor == 0: go to DONE with lo = all-ones and hi = dividend, regardless of signed_op.
- BUSY: perform one restoring step per cycle.
  - Shift {rem, quo} left by 1.
  - Trial-subtract the divisor magnitude on WIDTH+1 bits.
  - If non-negative, keep the difference and set the quotient LSB.
  - Increment the counter. After step ITERS-1, go to DONE.
- DONE:
  - lo = sign_q ? -quo : quo; hi = sign_r ? -rem : rem. Both are registered at the entry to DONE.
  - result_valid = 1 for this single cycle. Next state is IDLE unconditionally.
  - start is ignored in DONE, because it still belongs to the completing instruction.
- Signed magnitudes use two's-complement negation. 0x80000000 has magnitude 0x80000000 on the WIDTH+1-bit path, so no overflow trap.
- Overflow case: DIV 0x80000000 / 0xFFFFFFFF gives lo = 0x80000000, hi = 0.
- cancel in any state:
  - Next state is IDLE, with no result_valid.
  - hi/lo are unchanged. If cancel coincides with DONE, result_valid is suppressed and hi/lo keep their previous values.
- stall = !cancel & ((IDLE & start) | BUSY). It is 0 in DONE, so EX advances at the end of the DONE cycle.

## Timing
- Reset (resetn = 0 at an edge): state = IDLE, counter = 0, hi = 0, lo = 0, busy = 0, result_valid = 0. Reset mid-operation discards the operation.
- Normal latency:
  - start seen in IDLE at cycle 0.
  - BUSY during cycles 1..ITERS.
  - DONE and result_valid in cycle ITERS+1 (33 for the defaults).
  - stall high in cycles 0..ITERS.
- Divide by zero: start at cycle 0, DONE and result_valid at cycle 1; stall high in cycle 0 only.
- Back-to-back: a new start in the cycle after DONE (state IDLE) is accepted. Minimum spacing between result_valid pulses is ITERS+2 cycles.
- Cancel at cycle k: stall = 0 in cycle k, IDLE in cycle k+1. A start in cycle k+1 begins a fresh operation.

## Structure
- Shared header defines.vh gets DIV_IDLE/DIV_BUSY/DIV_DONE encodings and the DIV_ITERS default. It sits alongside the existing opcode/funct macros.
- Sub-module div_radix2_step is combinational. It takes {rem, quo} and the divisor magnitude, and returns the next {rem, quo}. The sequencer owns the FSM, counter, sign fix-up and output registers.
- hi/lo feed the HI/LO register write path. The write enable is result_valid, combined with the decoder's hilo_we in EX.

## Test plan
- DIVU 100 / 7, start at cycle 0 -> stall for cycles 0..32; result_valid at cycle 33 with lo = 14, hi = 2; busy = 0 at cycle 34.
- DIV 0xFFFFFFF9 (-7) / 2 -> lo = 0xFFFFFFFD, hi = 0xFFFFFFFF. DIV 0x80000000 / 0xFFFFFFFF -> lo = 0x80000000, hi = 0.
- DIVU 5 / 0 -> result_valid at cycle 1, lo = 0xFFFFFFFF, hi = 5.
- Start 100/7, cancel at cycle 10 -> stall = 0 at cycle 10, no result_valid, hi/lo keep their prior values. New start 9/4 at cycle 11 -> result_valid at cycle 44, lo = 2, hi = 1.
- Reset mid-operation: resetn = 0 at cycle 15 -> next cycle hi = lo = 0, busy = 0, no result_valid ever issued for that operation.
- Back-to-back: start held high through DONE, then a second DIVU 0xFFFFFFFF / 0x10 at cycle 34 -> first result at 33; no restart from the held start during DONE; second result at 67 with lo = 0x0FFFFFFF, hi = 0xF.
